link_rx: RTL and testbench
==========================

# link_rx

Serial receiver for the inter-board link between the local and remote game boards. It oversamples the remote board's TX pin and deframes 8N1 bytes. It then decodes each byte into remote key events (space, enter) and a 10-bit remote throw force, and presents them as single-cycle pulses and a held value to the game and turn FSMs. It sits between the remote-board input pin and the logic that currently consumes `btn_space_remote` / `btn_enter_remote` / `throw_force_cat`.

## Interface
- `CLKS_PER_BIT`, 564, clk cycles per serial bit (65 MHz / 115200 baud); must be ≥ 8.
- `clk  in  1` system clock, 65 MHz.
- `rst  in  1` reset; synchronous, active-high.
- `rx  in  1` asynchronous serial line from the remote board; idles high.
- `space_remote  out  1` one-cycle pulse: remote space pressed.
- `enter_remote  out  1` one-cycle pulse: remote enter pressed.
- `force_remote  out  10` last complete remote throw force; held until the next update.
- `force_valid  out  1` one-cycle pulse when `force_remote` updates.
- `frame_err  out  1` one-cycle pulse on a bad stop bit or a protocol violation.

## Operation
- **Synchronizer:** `rx` passes through a 2-FF synchronizer. Both FFs reset to 1.
- **Bit counter and sampling:** one bit-period counter, 0..CLKS_PER_BIT-1, and a 3-bit data index. Samples are taken at mid-bit.
- **Byte FSM**
  - IDLE: on synced rx == 0 → START; the counter clears.
  - START: at count CLKS_PER_BIT/2−1, sample the line.
    - Sample is 0 → DATA; the counter clears.
    - Sample is 1 (glitch) → IDLE, with no error.
  - DATA: every CLKS_PER_BIT cycles, shift in one bit, LSB first. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - Sample is 1 → DECODE.
    - Sample is 0 → pulse `frame_err`, discard the byte → WAIT_IDLE.
  - DECODE: one cycle; act on the byte → IDLE.
  - WAIT_IDLE: stay until synced rx == 1 → IDLE. This prevents a held-low break from re-triggering.
- **Decode of byte `b`:** `b[7:6]` is the opcode.
  - 00, key event:
    - `b[0]` → pulse `space_remote`.
    - `b[1]` → pulse `enter_remote`.
    - Both bits set → both pulse in the same cycle.
    - `b[5:2]` ignored.
  - 01, reserved: pulse `frame_err`.
  - 10, force high: latch `b[4:0]` into `hi_buf[4:0]`; set `hi_pend`. A second high byte overwrites the buffer without error.
  - 11, force low:
    - If `hi_pend` is set: `force_remote <= {hi_buf, b[4:0]}`, pulse `force_valid`, clear `hi_pend`.
    - If `hi_pend` is clear: pulse `frame_err`; `force_remote` is unchanged.
- **Pending state across events:** a key-event byte arriving between the high and low bytes is decoded normally and does not clear `hi_pend`. A frame error does clear `hi_pend`.
- **Reset values:** all pulses 0; `force_remote` 0; `hi_buf` 0; `hi_pend` 0; FSM IDLE.
- **Reset mid-frame:** the partial byte is dropped and no output pulses. The next start edge after reset is handled normally.

## Timing
- **Input latency:** 2 cycles from the `rx` pin to the synchronized value.
- **Start to stop sample:** the stop bit is sampled 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the synchronized falling edge, nominally.
- **Output latency:** output pulses assert exactly 1 cycle after the stop-bit sample (the DECODE cycle output register). Each pulse is 1 cycle wide.
- **Force update:** `force_remote` changes in the same cycle that `force_valid` is high.
- **Back-to-back bytes:** a byte whose start bit immediately follows the previous stop bit is received without loss. IDLE is re-entered before the next start edge can arrive.
- **Baud tolerance:** ±2 % mismatch is tolerated.

## Test plan
Run with CLKS_PER_BIT = 16.
- Send 0x01, then 0x02, then 0x03 → one `space_remote` pulse; then one `enter_remote` pulse; then both pulsing in the same cycle. Each pulse lands 1 cycle after its stop-bit sample.
- Send 0x95 then 0xCA → `force_remote` = 10'b10101_01010 = 0x2AA, with `force_valid` pulsing once. `force_remote` holds 0x2AA afterwards.
- Send 0xC3 with no preceding high byte → `frame_err` pulses once; `force_remote` stays 0; no `force_valid`.
- Send byte 0x01 with the stop bit driven 0 → `frame_err` pulses and there is no `space_remote`. Hold rx low for 40 bit times → no further pulses. Release rx, then send 0x01 → `space_remote` pulses.
- Apply a 4-cycle low glitch on an idle line → no outputs and no `frame_err`.
- Assert `rst` during bit 4 of 0x01 → no pulses. The next 0x01 sent after `rst` deasserts → `space_remote` pulses.

Source files
------------

// File: rtl/link_rx.sv
// Inter-board link receiver: oversamples the remote TX pin, deframes 8N1 bytes
// and decodes them into remote key pulses and a 10-bit remote throw force.
module link_rx #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       space_remote,
  output logic       enter_remote,
  output logic [9:0] force_remote,
  output logic       force_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DECODE,
    S_WAIT_IDLE
  } state_t;

  localparam logic [1:0] OP_KEY     = 2'b00;
  localparam logic [1:0] OP_RSVD    = 2'b01;
  localparam logic [1:0] OP_FORCE_H = 2'b10;
  localparam logic [1:0] OP_FORCE_L = 2'b11;

  state_t           state, state_nxt;
  logic             rx_p0, rx_p1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg;
  logic [4:0]       hi_buf;
  logic             hi_pend;
  logic             shift_en;
  logic             byte_done;
  logic             stop_bad;

  // Stage p0/p1: two-flop synchronizer; idles high so reset must not fake a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    idx_nxt   = idx;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_p1) state_nxt = S_START;
      end
      S_START: begin
        // Half a bit into the start bit: a line already back high was a glitch
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_p1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          idx_nxt  = idx + 3'd1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_p1) begin
            byte_done = 1'b1;
            state_nxt = S_DECODE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_DECODE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      S_WAIT_IDLE: begin
        // A held-low break must return high before another start is accepted
        cnt_nxt = '0;
        if (rx_p1) state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_p1, shreg[7:1]};
  end

  // Stage p2: decode registered on the stop-bit sample, so pulses appear in the DECODE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      space_remote <= 1'b0;
      enter_remote <= 1'b0;
      force_valid  <= 1'b0;
      frame_err    <= 1'b0;
      force_remote <= '0;
      hi_buf       <= '0;
      hi_pend      <= 1'b0;
    end else begin
      space_remote <= 1'b0;
      enter_remote <= 1'b0;
      force_valid  <= 1'b0;
      frame_err    <= 1'b0;
      if (stop_bad) begin
        frame_err <= 1'b1;
        hi_pend   <= 1'b0;
      end else if (byte_done) begin
        case (shreg[7:6])
          OP_KEY: begin
            space_remote <= shreg[0];
            enter_remote <= shreg[1];
          end
          OP_RSVD: begin
            frame_err <= 1'b1;
            hi_pend   <= 1'b0;
          end
          OP_FORCE_H: begin
            hi_buf  <= shreg[4:0];
            hi_pend <= 1'b1;
          end
          OP_FORCE_L: begin
            if (hi_pend) begin
              force_remote <= {hi_buf, shreg[4:0]};
              force_valid  <= 1'b1;
              hi_pend      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: frame_err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_link_rx.sv
// Scoreboard bench for link_rx: directed link scenarios followed by random byte
// traffic, each frame's expected outputs predicted from the byte protocol rules.
module tb_link_rx;

  localparam int CPB     = 16;
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       space_remote;
  logic       enter_remote;
  logic [9:0] force_remote;
  logic       force_valid;
  logic       frame_err;

  link_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .space_remote (space_remote),
    .enter_remote (enter_remote),
    .force_remote (force_remote),
    .force_valid  (force_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       space;
    logic       enter;
    logic       fv;
    logic       ferr;
    logic [9:0] frc;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [4:0] m_hi = '0;
  bit         m_pend = 0;
  logic [9:0] m_force = '0;
  logic [9:0] mon_force = '0;

  // Protocol model: what one received frame should produce, and when
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input int n);
    exp_t e;
    bit   emit;
    e.space = 0; e.enter = 0; e.fv = 0; e.ferr = 0;
    e.cyc = n + LATENCY;
    emit = 0;
    if (!stop_ok) begin
      e.ferr = 1; m_pend = 0; emit = 1;
    end else begin
      case (b[7:6])
        2'b00: begin
          e.space = b[0]; e.enter = b[1]; emit = (b[1:0] != 2'b00);
        end
        2'b01: begin
          e.ferr = 1; m_pend = 0; emit = 1;
        end
        2'b10: begin
          m_hi = b[4:0]; m_pend = 1;
        end
        default: begin
          if (m_pend) begin
            m_force = m_hi * 32 + b[4:0];
            e.fv = 1; m_pend = 0;
          end else begin
            e.ferr = 1;
          end
          emit = 1;
        end
      endcase
    end
    e.frc = m_force;
    if (emit) q.push_back(e);
  endtask

  // Called just after a rising edge; each of the 10 bit cells lasts exactly CPB cycles
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rst_pos);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    if (rst_pos < 0) model_frame(b, stop_ok, cyc);
    else begin
      m_pend = 0; m_force = '0; m_hi = '0;
    end
    for (int p = 0; p < 10; p++) begin
      if (p == rst_pos) rst = 1'b1;
      rx = fr[p];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (rst_pos >= 0) rst = 1'b0;
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) mon_force = '0;
    if (space_remote || enter_remote || force_valid || frame_err) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got space=%b enter=%b fv=%b ferr=%b, required none",
                 cyc, space_remote, enter_remote, force_valid, frame_err);
      end else begin
        e = q.pop_front();
        if (space_remote !== e.space || enter_remote !== e.enter || force_valid !== e.fv ||
            frame_err !== e.ferr || force_remote !== e.frc || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse cyc=%0d got space=%b enter=%b fv=%b ferr=%b force=%h, required cyc=%0d space=%b enter=%b fv=%b ferr=%b force=%h",
                   cyc, space_remote, enter_remote, force_valid, frame_err, force_remote,
                   e.cyc, e.space, e.enter, e.fv, e.ferr, e.frc);
        end
        if (e.fv) mon_force = e.frc;
      end
    end else begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missing_pulse cyc=%0d got no pulse, required space=%b enter=%b fv=%b ferr=%b at cyc=%0d",
                 cyc, e.space, e.enter, e.fv, e.ferr, e.cyc);
      end
      if (!rst) begin
        checks++;
        if (force_remote !== mon_force) begin
          errors++;
          $display("FAIL force_hold cyc=%0d got %h, required %h", cyc, force_remote, mon_force);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d got no completion, required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({space_remote, enter_remote, force_valid, frame_err} !== 4'b0000 || force_remote !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got pulses=%b force=%h, required pulses=0000 force=000",
               {space_remote, enter_remote, force_valid, frame_err}, force_remote);
    end
    idle(20);

    // key events, back to back
    send_frame(8'h01, 1, -1);
    send_frame(8'h02, 1, -1);
    send_frame(8'h03, 1, -1);
    idle(2 * CPB);

    // low byte without a high byte
    send_frame(8'hC3, 1, -1);
    idle(CPB);

    // force pair
    send_frame(8'h95, 1, -1);
    idle(3);
    send_frame(8'hCA, 1, -1);
    idle(4 * CPB);

    // bad stop bit followed by a long break
    send_frame(8'h01, 0, -1);
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle(3 * CPB);
    send_frame(8'h01, 1, -1);
    idle(2 * CPB);

    // short glitch on an idle line
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * CPB);

    // reset during data bit 4
    send_frame(8'h01, 1, 5);
    idle(2 * CPB);
    send_frame(8'h01, 1, -1);
    idle(2 * CPB);

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'($urandom);
        1: b = {2'b10, 6'($urandom)};
        2: b = {2'b11, 6'($urandom)};
        default: b = {2'b00, 6'($urandom)};
      endcase
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok, -1);
      if (!ok) idle(CPB);
      else idle($urandom_range(0, 2 * CPB));
    end
    idle(4 * CPB);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d outstanding, required 0", q.size());
    end
    checks++;
    if (force_remote !== m_force) begin
      errors++;
      $display("FAIL final_force got %h, required %h", force_remote, m_force);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
